// File: rtl/tts_controller.sv
// -----------------------------------------------------------------------------
// tts_controller
//
// Condenses the raw error, sync-lost and DDR3 overflow flags into one
// registered 4-bit TTS state for the DAQ link. Error and sync-lost flags are
// latched until software clears them. The overflow warning is debounced with
// hysteresis. Any move to a lower-priority state waits out a minimum dwell
// time, so the DAQ never sees the state chatter.
//
// Parameters
//   MIN_HOLD  cycles a non-disconnected state is held before a downgrade (>=1)
//   OVFL_ON   consecutive high overflow samples that assert the warning  (>=1)
//   OVFL_OFF  consecutive low overflow samples that clear the warning   (>=1)
//
// Ports
//   clk                in   clock
//   reset              in   synchronous, active-high reset
//   enable             in   DAQ link up / TTS enabled; low forces Disconnected
//   error_in[4:0]      in   {unknown_ttc, trig_rate, pll_unlock, data_corrupt, ttc_ready}
//   sync_lost_in[3:0]  in   {type_from_cm, type_from_tt, num_from_cm, num_from_tt}
//   overflow_in        in   raw DDR3 overflow warning
//   clear_errors       in   one-cycle pulse that clears the sticky latches
//   tts_state[3:0]     out  0000 Disc, 1100 Error, 0010 SyncLost, 0001 Ovfl, 1000 Ready
//   error_latched      out  sticky copy of error_in
//   sync_lost_latched  out  sticky copy of sync_lost_in
//   overflow_active    out  debounced overflow warning
//   tts_change         out  one-cycle pulse in the cycle after tts_state changed
//   tts_change_count   out  number of tts_state changes, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module tts_controller #(
    parameter int MIN_HOLD = 1024,
    parameter int OVFL_ON  = 16,
    parameter int OVFL_OFF = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [4:0]  error_in,
    input  logic [3:0]  sync_lost_in,
    input  logic        overflow_in,
    input  logic        clear_errors,
    output logic [3:0]  tts_state,
    output logic [4:0]  error_latched,
    output logic [3:0]  sync_lost_latched,
    output logic        overflow_active,
    output logic        tts_change,
    output logic [15:0] tts_change_count
);

    // State encoding is the TTS code itself, so tts_state is the state register.
    typedef enum logic [3:0] {
        ST_DISC      = 4'b0000,
        ST_ERROR     = 4'b1100,
        ST_SYNC_LOST = 4'b0010,
        ST_OVFL      = 4'b0001,
        ST_READY     = 4'b1000
    } state_t;

    localparam int HOLD_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    // One run counter serves both debounce directions; size it for the longer.
    localparam int RUN_MAX = (OVFL_ON > OVFL_OFF) ? OVFL_ON : OVFL_OFF;
    localparam int RUN_W   = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
    localparam logic [RUN_W-1:0]  ON_LAST   = RUN_W'(OVFL_ON - 1);
    localparam logic [RUN_W-1:0]  OFF_LAST  = RUN_W'(OVFL_OFF - 1);

    // ---------------------------------------------------------------- latches
    // Errors occupy [8:4], sync-lost flags [3:0].
    logic [8:0] r_latch;
    logic [8:0] w_latch_in;
    logic [8:0] w_latch_next;

    assign w_latch_in = {error_in, sync_lost_in};

    // A bit whose input is high on the clearing edge stays set.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_latch
            assign w_latch_next[gi] = w_latch_in[gi] | (r_latch[gi] & ~clear_errors);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_latch <= '0;
        end else begin
            r_latch <= w_latch_next;
        end
    end

    // --------------------------------------------------------------- debounce
    logic             r_ovfl_active;
    logic [RUN_W-1:0] r_run;

    // r_run counts samples that disagree with the current debounced value;
    // the flip happens on the edge that samples the final required one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovfl_active <= 1'b0;
            r_run         <= '0;
        end else if (overflow_in == r_ovfl_active) begin
            r_run <= '0;
        end else if (r_run == (r_ovfl_active ? OFF_LAST : ON_LAST)) begin
            r_ovfl_active <= ~r_ovfl_active;
            r_run         <= '0;
        end else begin
            r_run <= r_run + 1'b1;
        end
    end

    // -------------------------------------------------------------------- FSM
    function automatic logic [2:0] rank_of(input state_t s);
        case (s)
            ST_ERROR:     rank_of = 3'd4;
            ST_SYNC_LOST: rank_of = 3'd3;
            ST_OVFL:      rank_of = 3'd2;
            ST_READY:     rank_of = 3'd1;
            default:      rank_of = 3'd0;
        endcase
    endfunction

    state_t            r_state;
    state_t            r_prev_state;
    logic [HOLD_W-1:0] r_hold;
    logic              r_tts_change;
    logic [15:0]       r_change_count;
    state_t            w_req;
    state_t            w_next;

    // Requested class comes from the registered latches, which gives the
    // two-edge latency from a raw flag to tts_state.
    always_comb begin
        w_req = ST_READY;
        if (|r_latch[8:4]) begin
            w_req = ST_ERROR;
        end else if (|r_latch[3:0]) begin
            w_req = ST_SYNC_LOST;
        end else if (r_ovfl_active) begin
            w_req = ST_OVFL;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_DISC;
        end else if (r_state == ST_DISC) begin
            w_next = w_req;
        end else if (rank_of(w_req) > rank_of(r_state)) begin
            w_next = w_req;
        end else if ((rank_of(w_req) < rank_of(r_state)) && (r_hold == HOLD_LAST)) begin
            // r_hold saturates at HOLD_LAST, so equality means the dwell is over.
            w_next = w_req;
        end
    end

    // tts_change / count compare against the previous state, placing the
    // pulse in the cycle after the visible change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_DISC;
            r_prev_state   <= ST_DISC;
            r_hold         <= '0;
            r_tts_change   <= 1'b0;
            r_change_count <= '0;
        end else begin
            r_state      <= w_next;
            r_prev_state <= r_state;
            if (w_next != r_state) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_LAST) begin
                r_hold <= r_hold + 1'b1;
            end
            if (r_state != r_prev_state) begin
                r_tts_change <= 1'b1;
                if (r_change_count != 16'hFFFF) begin
                    r_change_count <= r_change_count + 16'd1;
                end
            end else begin
                r_tts_change <= 1'b0;
            end
        end
    end

    assign tts_state         = r_state;
    assign error_latched     = r_latch[8:4];
    assign sync_lost_latched = r_latch[3:0];
    assign overflow_active   = r_ovfl_active;
    assign tts_change        = r_tts_change;
    assign tts_change_count  = r_change_count;

endmodule

// File: tb/tb_tts_controller.sv
// -----------------------------------------------------------------------------
// tb_tts_controller
//
// Directed scenarios with spec-derived constants, followed by a randomized
// run compared every cycle against a behavioural model of the TTS rules, and
// a saturation run of the change counter.
// -----------------------------------------------------------------------------
module tb_tts_controller;

    localparam int MIN_HOLD = 8;
    localparam int OVFL_ON  = 4;
    localparam int OVFL_OFF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  error_in = '0;
    logic [3:0]  sync_lost_in = '0;
    logic        overflow_in = 1'b0;
    logic        clear_errors = 1'b0;
    logic [3:0]  tts_state;
    logic [4:0]  error_latched;
    logic [3:0]  sync_lost_latched;
    logic        overflow_active;
    logic        tts_change;
    logic [15:0] tts_change_count;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    logic [4:0] m_err = '0;
    logic [3:0] m_sync = '0;
    logic       m_ovfl = 1'b0;
    int         m_run = 0;
    logic [3:0] m_state = '0;
    logic [3:0] m_prev = '0;
    int         m_age = 0;
    logic       m_change = 1'b0;
    int         m_count = 0;

    tts_controller #(
        .MIN_HOLD (MIN_HOLD),
        .OVFL_ON  (OVFL_ON),
        .OVFL_OFF (OVFL_OFF)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .error_in          (error_in),
        .sync_lost_in      (sync_lost_in),
        .overflow_in       (overflow_in),
        .clear_errors      (clear_errors),
        .tts_state         (tts_state),
        .error_latched     (error_latched),
        .sync_lost_latched (sync_lost_latched),
        .overflow_active   (overflow_active),
        .tts_change        (tts_change),
        .tts_change_count  (tts_change_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    function automatic int rank(input logic [3:0] s);
        case (s)
            4'b1100: return 4;
            4'b0010: return 3;
            4'b0001: return 2;
            4'b1000: return 1;
            default: return 0;
        endcase
    endfunction

    // Apply one clock edge to the model, using the inputs present at the edge.
    task automatic model_update();
        logic [3:0] req;
        logic [3:0] nxt;
        if (reset) begin
            m_err = '0; m_sync = '0; m_ovfl = 1'b0; m_run = 0;
            m_state = '0; m_prev = '0; m_age = 0; m_change = 1'b0; m_count = 0;
            return;
        end
        if (m_err != 0)       req = 4'b1100;
        else if (m_sync != 0) req = 4'b0010;
        else if (m_ovfl)      req = 4'b0001;
        else                  req = 4'b1000;
        if (!enable)                                              nxt = 4'b0000;
        else if (m_state == 4'b0000)                              nxt = req;
        else if (rank(req) > rank(m_state))                       nxt = req;
        else if (rank(req) < rank(m_state) && m_age >= MIN_HOLD - 1) nxt = req;
        else                                                      nxt = m_state;
        m_change = (m_state != m_prev);
        if (m_change && m_count < 65535) m_count++;
        m_prev  = m_state;
        m_age   = (nxt != m_state) ? 0 : m_age + 1;
        m_state = nxt;
        m_err  = clear_errors ? error_in : (m_err | error_in);
        m_sync = clear_errors ? sync_lost_in : (m_sync | sync_lost_in);
        if (overflow_in != m_ovfl) begin
            m_run++;
            if (m_run == (m_ovfl ? OVFL_OFF : OVFL_ON)) begin
                m_ovfl = ~m_ovfl;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        n_checks++; if (tts_state !== 4'b0000) $display("FAIL reset_state: got %b want 0000", tts_state); else n_pass++;
        n_checks++; if ({error_latched, sync_lost_latched, overflow_active, tts_change} !== 11'd0)
            $display("FAIL reset_flags: got %b want 0", {error_latched, sync_lost_latched, overflow_active, tts_change}); else n_pass++;
        n_checks++; if (tts_change_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", tts_change_count); else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_enable();
        enable = 1'b1;
        step();
        n_checks++; if (tts_state !== 4'b1000) $display("FAIL enable_ready: got %b want 1000", tts_state); else n_pass++;
        n_checks++; if (tts_change !== 1'b0) $display("FAIL enable_change_early: got %b want 0", tts_change); else n_pass++;
        step();
        n_checks++; if (tts_change !== 1'b1 || tts_change_count !== 16'd1)
            $display("FAIL enable_change: got %b/%0d want 1/1", tts_change, tts_change_count); else n_pass++;
        step();
        n_checks++; if (tts_change !== 1'b0 || tts_change_count !== 16'd1)
            $display("FAIL enable_change_pulse: got %b/%0d want 0/1", tts_change, tts_change_count); else n_pass++;
        $display("test_enable done");
    endtask

    task automatic test_error_hold();
        int cyc;
        repeat (10) step();
        error_in = 5'b00100;
        step();
        error_in = 5'b00000;
        n_checks++; if (error_latched !== 5'b00100 || tts_state !== 4'b1000)
            $display("FAIL err_latch: got %b/%b want 00100/1000", error_latched, tts_state); else n_pass++;
        step();
        n_checks++; if (tts_state !== 4'b1100) $display("FAIL err_enter: got %b want 1100", tts_state); else n_pass++;
        step(); step();
        n_checks++; if (tts_state !== 4'b1100 || error_latched !== 5'b00100)
            $display("FAIL err_sticky: got %b/%b want 1100/00100", tts_state, error_latched); else n_pass++;
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        n_checks++; if (error_latched !== 5'b00000) $display("FAIL err_clear: got %b want 00000", error_latched); else n_pass++;
        cyc = 3;
        while (tts_state == 4'b1100 && cyc < 30) begin step(); cyc++; end
        n_checks++; if (cyc != MIN_HOLD || tts_state !== 4'b1000)
            $display("FAIL err_hold: left after %0d cycles to %b, want %0d to 1000", cyc, tts_state, MIN_HOLD); else n_pass++;
        $display("test_error_hold done");
    endtask

    task automatic test_sync_then_error();
        int cyc;
        sync_lost_in = 4'b0010;
        step();
        sync_lost_in = 4'b0000;
        n_checks++; if (sync_lost_latched !== 4'b0010) $display("FAIL sync_latch: got %b want 0010", sync_lost_latched); else n_pass++;
        step();
        n_checks++; if (tts_state !== 4'b0010) $display("FAIL sync_enter: got %b want 0010", tts_state); else n_pass++;
        error_in = 5'b00001;
        step();
        error_in = 5'b00000;
        step();
        n_checks++; if (tts_state !== 4'b1100) $display("FAIL sync_to_err: got %b want 1100", tts_state); else n_pass++;
        // clear only errors: the sync flag is still driven during the clear
        sync_lost_in = 4'b0010; clear_errors = 1'b1;
        step();
        sync_lost_in = 4'b0000; clear_errors = 1'b0;
        n_checks++; if (error_latched !== 5'b00000 || sync_lost_latched !== 4'b0010)
            $display("FAIL sel_clear: got %b/%b want 00000/0010", error_latched, sync_lost_latched); else n_pass++;
        cyc = 0;
        while (tts_state == 4'b1100 && cyc < 30) begin step(); cyc++; end
        n_checks++; if (tts_state !== 4'b0010 || cyc != MIN_HOLD - 1)
            $display("FAIL err_to_sync: got %b after %0d want 0010 after %0d", tts_state, cyc, MIN_HOLD - 1); else n_pass++;
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        cyc = 0;
        while (tts_state != 4'b1000 && cyc < 30) begin step(); cyc++; end
        n_checks++; if (tts_state !== 4'b1000) $display("FAIL sync_release: got %b want 1000", tts_state); else n_pass++;
        $display("test_sync_then_error done");
    endtask

    task automatic test_overflow();
        int cyc;
        overflow_in = 1'b1; repeat (3) step();
        overflow_in = 1'b0; step();
        overflow_in = 1'b1; repeat (OVFL_ON - 1) step();
        n_checks++; if (overflow_active !== 1'b0) $display("FAIL ovfl_early: got %b want 0", overflow_active); else n_pass++;
        step();
        n_checks++; if (overflow_active !== 1'b1 || tts_state !== 4'b1000)
            $display("FAIL ovfl_on: got %b/%b want 1/1000", overflow_active, tts_state); else n_pass++;
        step();
        n_checks++; if (tts_state !== 4'b0001) $display("FAIL ovfl_state: got %b want 0001", tts_state); else n_pass++;
        overflow_in = 1'b0; repeat (OVFL_OFF - 1) step();
        overflow_in = 1'b1; step();
        n_checks++; if (overflow_active !== 1'b1 || tts_state !== 4'b0001)
            $display("FAIL ovfl_hyst: got %b/%b want 1/0001", overflow_active, tts_state); else n_pass++;
        overflow_in = 1'b0; repeat (OVFL_OFF - 1) step();
        n_checks++; if (overflow_active !== 1'b1) $display("FAIL ovfl_off_early: got %b want 1", overflow_active); else n_pass++;
        step();
        n_checks++; if (overflow_active !== 1'b0) $display("FAIL ovfl_off: got %b want 0", overflow_active); else n_pass++;
        cyc = 0;
        while (tts_state != 4'b1000 && cyc < 30) begin step(); cyc++; end
        n_checks++; if (tts_state !== 4'b1000) $display("FAIL ovfl_release: got %b want 1000", tts_state); else n_pass++;
        $display("test_overflow done");
    endtask

    task automatic test_clear_while_set();
        error_in = 5'b01000;
        step(); step();
        n_checks++; if (tts_state !== 4'b1100) $display("FAIL cws_enter: got %b want 1100", tts_state); else n_pass++;
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        n_checks++; if (error_latched !== 5'b01000) $display("FAIL cws_latch: got %b want 01000", error_latched); else n_pass++;
        repeat (12) step();
        n_checks++; if (tts_state !== 4'b1100) $display("FAIL cws_state: got %b want 1100", tts_state); else n_pass++;
        error_in = 5'b00000;
        $display("test_clear_while_set done");
    endtask

    task automatic test_disable();
        int cyc;
        enable = 1'b0;
        step();
        n_checks++; if (tts_state !== 4'b0000 || error_latched !== 5'b01000)
            $display("FAIL dis_state: got %b/%b want 0000/01000", tts_state, error_latched); else n_pass++;
        enable = 1'b1;
        step();
        n_checks++; if (tts_state !== 4'b1100) $display("FAIL dis_reenter: got %b want 1100", tts_state); else n_pass++;
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        cyc = 0;
        while (tts_state != 4'b1000 && cyc < 30) begin step(); cyc++; end
        n_checks++; if (tts_state !== 4'b1000) $display("FAIL dis_release: got %b want 1000", tts_state); else n_pass++;
        $display("test_disable done");
    endtask

    task automatic test_random();
        logic ovfl_level;
        int   bad;
        ovfl_level = 1'b0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 399) == 0);
            enable       = ($urandom_range(0, 39) != 0);
            error_in     = ($urandom_range(0, 59) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
            sync_lost_in = ($urandom_range(0, 49) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            clear_errors = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 6) == 0) ovfl_level = ~ovfl_level;
            overflow_in  = ovfl_level ^ ($urandom_range(0, 15) == 0);
            step();
            n_checks++;
            if ({tts_state, error_latched, sync_lost_latched, overflow_active, tts_change, tts_change_count}
                !== {m_state, m_err, m_sync, m_ovfl, m_change, 16'(m_count)}) begin
                bad++;
                $display("FAIL random cycle %0d: state=%b err=%b sync=%b ovfl=%b chg=%b cnt=%0d want %b %b %b %b %b %0d",
                         i, tts_state, error_latched, sync_lost_latched, overflow_active, tts_change, tts_change_count,
                         m_state, m_err, m_sync, m_ovfl, m_change, m_count);
            end else begin
                n_pass++;
            end
        end
        reset = 1'b0; error_in = '0; sync_lost_in = '0; clear_errors = 1'b0; overflow_in = 1'b0;
        $display("test_random done, %0d cycle mismatches", bad);
    endtask

    task automatic test_saturation();
        reset = 1'b1; enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 70000; i++) begin
            enable = ~enable;
            step();
        end
        enable = 1'b1;
        step(); step();
        n_checks++; if (tts_change_count !== 16'hFFFF || m_count != 65535)
            $display("FAIL sat_count: got %h want ffff", tts_change_count); else n_pass++;
        $display("test_saturation done");
    endtask

    task automatic test_reset_midway();
        error_in = 5'b11111; sync_lost_in = 4'b1111; overflow_in = 1'b1;
        repeat (8) step();
        reset = 1'b1;
        step();
        n_checks++; if ({tts_state, error_latched, sync_lost_latched, overflow_active, tts_change, tts_change_count} !== 31'd0)
            $display("FAIL mid_reset: got %b %b %b %b %b %0d want all 0", tts_state, error_latched,
                     sync_lost_latched, overflow_active, tts_change, tts_change_count); else n_pass++;
        reset = 1'b0; error_in = '0; sync_lost_in = '0; overflow_in = 1'b0;
        $display("test_reset_midway done");
    endtask

    initial begin
        test_reset();
        test_enable();
        test_error_hold();
        test_sync_then_error();
        test_overflow();
        test_clear_while_set();
        test_disable();
        test_random();
        test_saturation();
        test_reset_midway();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
